reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_DOM, default 4, number of sequenced reset domains (1..16).
REQ-002 Parameter HOLD_CYC, default 16, cycles all domain resets are held asserted before the first release (>=1).
REQ-003 Parameter GAP_CYC, default 4, cycles between ready of domain i and release of domain i+1 (>=1).
REQ-004 Parameter TMO_CYC, default 256, ready-wait timeout in cycles (>=2), used only with watchdog.
REQ-005 The block SHALL use one clock, clk; reset is synchronous and active-high on port rst, already synchronized to clk upstream.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 sw_req  input  1  software reset request, level, held by requester until sw_ack.
REQ-009 sw_ack  output  1  one-cycle pulse accepting sw_req.
REQ-010 dom_ready  input  N_DOM  per-domain "out of reset and alive" indication.
REQ-011 dom_rst  output  N_DOM  per-domain active-high reset, bit 0 released first.
REQ-012 seq_done  output  1  high while all domains are released and ready.
REQ-013 err  output  1  sticky watchdog error flag.

Function
REQ-014 The block SHALL implement states ASSERT, GAP, WAIT_RDY, DONE; index register idx (0..N_DOM-1).
REQ-015 ASSERT: all dom_rst=1, counter loads HOLD_CYC; on the HOLD_CYC-th edge with rst=0, dom_rst[0] SHALL go 0 and the state SHALL become WAIT_RDY, idx=0.
REQ-016 WAIT_RDY: dom_ready[idx] SHALL be sampled each edge; when 1 and idx<N_DOM-1, go to GAP with counter=GAP_CYC; when 1 and idx=N_DOM-1, go to DONE.
REQ-017 GAP: on the GAP_CYC-th edge, dom_rst[idx+1] SHALL go 0, idx increments, state returns to WAIT_RDY.
REQ-018 dom_ready[j] SHALL be ignored for any j whose dom_rst[j]=1 or j!=idx; a released domain stays released (dom_rst bits only fall during a sequence).
REQ-019 DONE: seq_done=1 (registered, asserts the edge DONE is entered); all dom_rst=0.
REQ-020 sw_req SHALL be accepted only in DONE: sw_ack pulses for exactly one cycle, state goes to ASSERT, all dom_rst=1 and seq_done=0 on that same edge.
REQ-021 sw_req outside DONE SHALL be ignored without ack; the still-held request is accepted once DONE is reached.
REQ-022 Loss of dom_ready after DONE SHALL NOT retrigger the sequence.
REQ-023 Counters SHALL be sized $clog2(max(HOLD_CYC,GAP_CYC,TMO_CYC)+1) bits; no wrap permitted.

Reset
REQ-024 On any edge with rst=1: state=ASSERT, idx=0, counter=HOLD_CYC, dom_rst=all 1, sw_ack=0, seq_done=0, err=0, regardless of current state.
REQ-025 rst held high SHALL keep all outputs at reset values; HOLD_CYC counting SHALL begin on the first edge with rst=0.

Configuration
REQ-026 With macro RST_SEQ_WDOG_EN defined: in WAIT_RDY, if dom_ready[idx] is not seen within TMO_CYC edges, err SHALL set (sticky until rst) and the state SHALL return to ASSERT, retrying the full sequence.
REQ-027 Without RST_SEQ_WDOG_EN: WAIT_RDY waits indefinitely, err SHALL be tied 0, TMO_CYC unused, no timeout logic present.

Structure
REQ-028 Package rst_seq_pkg SHALL hold the state enum type and default constants for HOLD_CYC, GAP_CYC, TMO_CYC.
REQ-029 One sub-module rst_seq_cnt (loadable down counter with zero flag) SHALL be shared by hold, gap and timeout counting.

Verification (N_DOM=4, HOLD_CYC=16, GAP_CYC=4, TMO_CYC=256)
REQ-030 rst 1->0, dom_ready tied 4'hF -> dom_rst[0] falls on edge 16; dom_rst[1..3] fall on edges 21, 26, 31; seq_done=1 at edge 32.
REQ-031 In DONE, sw_req=1 held -> sw_ack one-cycle pulse, dom_rst=4'hF and seq_done=0 same edge, sequence repeats with identical timing.
REQ-032 sw_req asserted during GAP -> no sw_ack until DONE, then accepted on first DONE edge.
REQ-033 rst pulsed 1 cycle while idx=2 in WAIT_RDY -> dom_rst=4'hF next edge, full sequence restarts from ASSERT.
REQ-034 RST_SEQ_WDOG_EN defined, dom_ready[1] stuck 0 -> after 256 edges in WAIT_RDY err=1, dom_rst=4'hF, retry; err stays 1 until rst.
REQ-035 Macro undefined, dom_ready[1] stuck 0 for 1000 cycles -> idx stays 1, err=0; raise dom_ready[1] -> sequence completes normally.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and default timing constants for the reset sequencer.
// The optional watchdog is enabled with the RST_SEQ_WDOG_EN macro in reset_sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_GAP      = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_e;

  localparam int DEF_HOLD_CYC = 16;
  localparam int DEF_GAP_CYC  = 4;
  localparam int DEF_TMO_CYC  = 256;

  // The counter has to hold the largest of the three interval lengths.
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc, input int tmo_cyc);
    int max_v;
    max_v = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    max_v = (tmo_cyc > max_v) ? tmo_cyc : max_v;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down counter shared by the hold, gap and ready-timeout intervals.
// Flags: zero when empty, last when the current cycle ends the interval.
module rst_seq_cnt #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt_r;

  // Load wins over decrement; the count saturates at zero instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && !zero) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});
  assign last = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_DOM reset domains one at a time, waiting for each to report ready.
// Define RST_SEQ_WDOG_EN to add the ready-wait watchdog (sticky err plus full retry).
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int TMO_CYC  = DEF_TMO_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_req,
  output logic             sw_ack,
  input  logic [N_DOM-1:0] dom_ready,
  output logic [N_DOM-1:0] dom_rst,
  output logic             seq_done,
  output logic             err
);

  localparam int CNT_W = cnt_width(HOLD_CYC, GAP_CYC, TMO_CYC);
  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);
`ifdef RST_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TMO_CYC);
`endif

  seq_state_e       state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [N_DOM-1:0] dom_rst_r, dom_rst_nxt_s;
  logic             sw_ack_r, sw_ack_nxt_s;
  logic             seq_done_r, seq_done_nxt_s;
  logic             ready_sel_s;
  logic             cnt_load_s, cnt_dec_s, cnt_zero_s, cnt_last_s, cnt_expire_s;
  logic [CNT_W-1:0] cnt_val_s;
`ifdef RST_SEQ_WDOG_EN
  logic             err_r, err_nxt_s;
`endif

  rst_seq_cnt #(
    .CNT_W  (CNT_W),
    .RST_VAL(HOLD_CYC)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load_s),
    .load_val(cnt_val_s),
    .dec     (cnt_dec_s),
    .zero    (cnt_zero_s),
    .last    (cnt_last_s)
  );

  // An empty counter also ends the interval so a bad load cannot stall the FSM
  assign cnt_expire_s = cnt_last_s | cnt_zero_s;

  // Only the ready bit of the domain currently being waited on is looked at
  always_comb begin
    ready_sel_s = 1'b0;
    for (int j = 0; j < N_DOM; j++) begin
      if (j == int'(idx_r)) begin
        ready_sel_s = dom_ready[j];
      end else begin
        ready_sel_s = ready_sel_s;
      end
    end
  end

  // Next-state, counter control and next output values
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    dom_rst_nxt_s = dom_rst_r;
    sw_ack_nxt_s  = 1'b0;
    cnt_load_s    = 1'b0;
    cnt_val_s     = HOLD_LD;
    cnt_dec_s     = 1'b0;
`ifdef RST_SEQ_WDOG_EN
    err_nxt_s     = err_r;
`endif
    case (state_r)
      ST_ASSERT: begin
        dom_rst_nxt_s = {N_DOM{1'b1}};
        if (cnt_expire_s) begin
          dom_rst_nxt_s[0] = 1'b0;
          idx_nxt_s        = {IDX_W{1'b0}};
          state_nxt_s      = ST_WAIT_RDY;
`ifdef RST_SEQ_WDOG_EN
          cnt_load_s       = 1'b1;
          cnt_val_s        = TMO_LD;
`endif
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_WAIT_RDY: begin
        if (ready_sel_s) begin
          if (idx_r == IDX_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_GAP;
            cnt_load_s  = 1'b1;
            cnt_val_s   = GAP_LD;
          end
        end else begin
`ifdef RST_SEQ_WDOG_EN
          if (cnt_expire_s) begin
            err_nxt_s     = 1'b1;
            state_nxt_s   = ST_ASSERT;
            idx_nxt_s     = {IDX_W{1'b0}};
            dom_rst_nxt_s = {N_DOM{1'b1}};
            cnt_load_s    = 1'b1;
            cnt_val_s     = HOLD_LD;
          end else begin
            cnt_dec_s = 1'b1;
          end
`else
          state_nxt_s = ST_WAIT_RDY;
`endif
        end
      end
      ST_GAP: begin
        if (cnt_expire_s) begin
          for (int j = 0; j < N_DOM; j++) begin
            if (j == int'(idx_r) + 32'sd1) begin
              dom_rst_nxt_s[j] = 1'b0;
            end else begin
              dom_rst_nxt_s[j] = dom_rst_r[j];
            end
          end
          idx_nxt_s   = idx_r + IDX_W'(1);
          state_nxt_s = ST_WAIT_RDY;
`ifdef RST_SEQ_WDOG_EN
          cnt_load_s  = 1'b1;
          cnt_val_s   = TMO_LD;
`endif
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_DONE: begin
        dom_rst_nxt_s = {N_DOM{1'b0}};
        if (sw_req) begin
          sw_ack_nxt_s  = 1'b1;
          state_nxt_s   = ST_ASSERT;
          idx_nxt_s     = {IDX_W{1'b0}};
          dom_rst_nxt_s = {N_DOM{1'b1}};
          cnt_load_s    = 1'b1;
          cnt_val_s     = HOLD_LD;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s   = ST_ASSERT;
        idx_nxt_s     = {IDX_W{1'b0}};
        dom_rst_nxt_s = {N_DOM{1'b1}};
        cnt_load_s    = 1'b1;
        cnt_val_s     = HOLD_LD;
      end
    endcase
    seq_done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_ASSERT;
      idx_r      <= {IDX_W{1'b0}};
      dom_rst_r  <= {N_DOM{1'b1}};
      sw_ack_r   <= 1'b0;
      seq_done_r <= 1'b0;
`ifdef RST_SEQ_WDOG_EN
      err_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      dom_rst_r  <= dom_rst_nxt_s;
      sw_ack_r   <= sw_ack_nxt_s;
      seq_done_r <= seq_done_nxt_s;
`ifdef RST_SEQ_WDOG_EN
      err_r      <= err_nxt_s;
`endif
    end
  end

  assign dom_rst  = dom_rst_r;
  assign sw_ack   = sw_ack_r;
  assign seq_done = seq_done_r;
`ifdef RST_SEQ_WDOG_EN
  assign err      = err_r;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timeline model predicts every output change
// (edge number and value); a monitor compares each observed change against that queue.
module tb_reset_sequencer;

  localparam int N     = 4;
  localparam int HOLD  = 16;
  localparam int GAP   = 4;
  localparam int TMO   = 256;
  localparam int VW    = N + 3;
  localparam int BIG   = 32'h3fff_ffff;
  localparam int LIMIT = 20000;
  localparam int NPLAN = 9;

  localparam int K_EXACT = 0;
  localparam int K_SWGAP = 1;
  localparam int K_RAND  = 2;
  localparam int K_STUCK = 3;
  localparam int K_RST   = 4;
  localparam int K_LAST  = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sw_req = 1'b0;
  logic         sw_ack;
  logic [N-1:0] dom_ready = '0;
  logic [N-1:0] dom_rst;
  logic         seq_done;
  logic         err;

  reset_sequencer #(
    .N_DOM(N), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_ack(sw_ack),
    .dom_ready(dom_ready), .dom_rst(dom_rst), .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;
  int first_done_e = -1;

  // Scoreboard: expected output changes as (edge, {err, seq_done, sw_ack, dom_rst})
  int            exp_e_q[$];
  logic [VW-1:0] exp_v_q[$];

  // Timeline of the sequence currently being planned
  int            rel_e[N];
  int            w_e[N];
  int            q_e, acc_e, rst_e, done_e, next_start, chk_e;
  bit            err_m;
  logic [VW-1:0] cur_m;
  int            kind_tab[NPLAN] = '{K_EXACT, K_EXACT, K_SWGAP, K_RAND, K_STUCK,
                                     K_RAND, K_RST, K_RAND, K_LAST};

  function automatic logic [VW-1:0] mk(input bit er, input bit dn, input bit ak,
                                       input logic [N-1:0] dr);
    return {er, dn, ak, dr};
  endfunction

  task automatic push_ev(input int e, input logic [VW-1:0] v);
    if (v != cur_m) begin
      exp_e_q.push_back(e);
      exp_v_q.push_back(v);
      cur_m = v;
    end
  endtask

  // Sequence whose hold interval starts counting after edge s: domain j is
  // released at rel_e[j], is seen ready at w_e[j], next release GAP edges later.
  task automatic plan(input int s, input int kind);
    int t;
    int d;
    logic [N-1:0] dr;
    for (int j = 0; j < N; j++) begin
      rel_e[j] = BIG;
      w_e[j]   = BIG;
    end
    q_e = BIG; acc_e = BIG; rst_e = BIG; done_e = BIG; next_start = BIG; chk_e = BIG;
    dr = '1;
    t  = s + HOLD;
    for (int j = 0; j < N; j++) begin
      rel_e[j] = t;
      dr[j]    = 1'b0;
      push_ev(t, mk(err_m, 1'b0, 1'b0, dr));
      d = (kind == K_EXACT) ? 1 : int'($urandom_range(6, 1));
      if (kind == K_STUCK && j == 1) begin
        d = 1000;
`ifndef RST_SEQ_WDOG_EN
        chk_e = t + 500;
`endif
      end
      if (kind == K_RST && j == 2) begin
        rst_e = t + 1;
        err_m = 1'b0;
        push_ev(rst_e, mk(1'b0, 1'b0, 1'b0, {N{1'b1}}));
        next_start = rst_e;
        return;
      end
`ifdef RST_SEQ_WDOG_EN
      if (d > TMO) begin
        err_m = 1'b1;
        push_ev(t + TMO, mk(1'b1, 1'b0, 1'b0, {N{1'b1}}));
        next_start = t + TMO;
        return;
      end
`endif
      w_e[j] = t + d;
      if (j < N - 1) t = w_e[j] + GAP;
      else           done_e = w_e[j];
    end
    push_ev(done_e, mk(err_m, 1'b1, 1'b0, {N{1'b0}}));
    if (kind == K_LAST) return;
    if (kind == K_EXACT)      q_e = done_e + 3;
    else if (kind == K_SWGAP) q_e = w_e[0] + 1;
    else                      q_e = s + int'($urandom_range(done_e - s + 6, HOLD + 1));
    acc_e = (q_e > done_e) ? q_e : done_e + 1;
    push_ev(acc_e,     mk(err_m, 1'b0, 1'b1, {N{1'b1}}));
    push_ev(acc_e + 1, mk(err_m, 1'b0, 1'b0, {N{1'b1}}));
    next_start = acc_e;
  endtask

  // Monitor: every change of the output vector must match the next queued event
  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] prev_v;
    logic [VW-1:0] ev;
    int            ee;
    prev_v = '0;
    forever begin
      @(negedge clk);
      v = {err, seq_done, sw_ack, dom_rst};
      if (cyc >= 3 && v !== prev_v) begin
        n_vec++;
        if (exp_e_q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_change edge %0d: got %b, required unchanged %b", cyc, v, prev_v);
        end else begin
          ee = exp_e_q.pop_front();
          ev = exp_v_q.pop_front();
          if (ee != cyc || ev !== v) begin
            n_mis++;
            $display("FAIL out_event: got %b at edge %0d, required %b at edge %0d", v, cyc, ev, ee);
          end
        end
        if (first_done_e < 0 && v[VW-2] === 1'b1 && prev_v[VW-2] === 1'b0) first_done_e = cyc;
      end
      prev_v = v;
    end
  end

  // Stimulus: drives inputs for edge e_cur+1 from the planned timeline
  initial begin
    int  e_cur;
    int  e;
    int  plan_idx;
    bit  fin;
    for (int j = 0; j < N; j++) begin
      rel_e[j] = BIG;
      w_e[j]   = BIG;
    end
    q_e = BIG; acc_e = BIG; rst_e = BIG; done_e = BIG; chk_e = BIG;
    next_start = 3;
    plan_idx   = 0;
    err_m      = 1'b0;
    cur_m      = mk(1'b0, 1'b0, 1'b0, {N{1'b1}});
    fin        = 1'b0;
    while (!fin) begin
      @(posedge clk);
      #1;
      e_cur = cyc;
      if (e_cur == 2) begin
        n_vec++;
        if ({err, seq_done, sw_ack, dom_rst} !== mk(1'b0, 1'b0, 1'b0, {N{1'b1}})) begin
          n_mis++;
          $display("FAIL reset_state: got %b, required %b", {err, seq_done, sw_ack, dom_rst},
                   mk(1'b0, 1'b0, 1'b0, {N{1'b1}}));
        end
      end
      if (e_cur == next_start && plan_idx < NPLAN) begin
        plan(e_cur, kind_tab[plan_idx]);
        plan_idx++;
      end
      if (e_cur == chk_e) begin
        n_vec++;
        if (dom_rst !== 4'b1100 || err !== 1'b0) begin
          n_mis++;
          $display("FAIL stuck_wait: got dom_rst=%b err=%b, required dom_rst=1100 err=0", dom_rst, err);
        end
      end
      if (plan_idx == NPLAN && done_e != BIG && e_cur >= done_e + 20) fin = 1'b1;
      if (e_cur >= LIMIT) begin
        n_vec++;
        n_mis++;
        $display("FAIL cycle_budget: got %0d edges, required completion before %0d", e_cur, LIMIT);
        fin = 1'b1;
      end
      e      = e_cur + 1;
      rst    = (e <= 3) || (e == rst_e);
      sw_req = (e >= q_e) && (e <= acc_e);
      for (int j = 0; j < N; j++) begin
        if (e > rel_e[j] && e <= w_e[j]) dom_ready[j] = (e == w_e[j]);
        else                             dom_ready[j] = 1'($urandom_range(1, 0));
      end
    end
    while (exp_e_q.size() != 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL missing_event: got nothing, required %b at edge %0d",
               exp_v_q.pop_front(), exp_e_q.pop_front());
    end
    // rst is last sampled at edge 3, so sequence edge 32 is absolute edge 35
    n_vec++;
    if (first_done_e != 35) begin
      n_mis++;
      $display("FAIL first_done_edge: got %0d, required 35", first_done_e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
